// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw
// Store-side narrowing unit for a word-only data memory. A byte or halfword
// store is merged into the addressed word with a read-modify-write sequence.
// A word store is written directly. An illegal request is rejected with a
// done/misaligned pulse and causes no memory access.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req_valid/req_ready, req_addr, req_wdata, req_size
//                  store request handshake (size 00 byte, 01 half, 10 word)
//   done           one-cycle completion pulse
//   misaligned     high with done when the request was rejected
//   mem_addr       word address of the latched request
//   mem_rd         read strobe
//   mem_rdata      read data, valid RD_LATENCY cycles after mem_rd
//   mem_wr         write strobe
//   mem_wdata      full word to write
// All outputs come from state or registers only.
module store_narrow_rmw #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        misaligned,
  output logic [29:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  // Holds the store data from accept, and the merged word after the read.
  logic [31:0] data_q, data_d;
  logic        accept_s;
  logic        illegal_s;

  // Overlay the narrowed store data onto the word read from memory.
  function automatic logic [31:0] merge_word(input logic [31:0] rd,
                                             input logic [31:0] wd,
                                             input logic [1:0]  off,
                                             input logic [1:0]  sz);
    logic [31:0] m;
    m = rd;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        2'd3:    m[31:24] = wd[7:0];
        default: m = rd;
      endcase
    end else begin
      if (off[1]) begin
        m[31:16] = wd[15:0];
      end else begin
        m[15:0] = wd[15:0];
      end
    end
    return m;
  endfunction

  assign accept_s  = req_valid && (state_q == S_IDLE);
  assign illegal_s = (req_size == 2'b11) ||
                     ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // Next-state logic and register updates for the store sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d = req_addr;
          size_d = req_size;
          data_d = req_wdata;
          if (illegal_s) begin
            state_d = S_ERR;
          end else if (req_size == SZ_WORD) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          data_d  = merge_word(mem_rdata, data_q, addr_q[1:0], size_q);
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any pending operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_rd     = (state_q == S_READ);
  assign mem_wr     = (state_q == S_WRITE);
  assign done       = (state_q == S_WRITE) || (state_q == S_ERR);
  assign misaligned = (state_q == S_ERR);
  assign mem_addr   = addr_q[31:2];
  assign mem_wdata  = data_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: two instances (read latency 1 and 3) share the
// request inputs; each has its own latency-accurate memory model and its own
// expectation queue, popped by a monitor whenever that instance pulses done.
module tb_store_narrow_rmw;

  typedef struct {
    bit          err;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          done_cyc;
    int          rd_exp;
    int          rd_cyc;
  } exp_t;

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;

  logic [1:0]  ready, done, mis, mrd, mwr;
  logic [29:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic [31:0] mrdata [2];

  logic [31:0] mem [2][16];
  logic        vp  [2][4];
  logic [31:0] dp  [2][4];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rd_cnt [2];
  int   rd_at  [2];

  store_narrow_rmw #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[0]),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .done(done[0]), .misaligned(mis[0]), .mem_addr(maddr[0]), .mem_rd(mrd[0]),
    .mem_rdata(mrdata[0]), .mem_wr(mwr[0]), .mem_wdata(mwdata[0])
  );

  store_narrow_rmw #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[1]),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .done(done[1]), .misaligned(mis[1]), .mem_addr(maddr[1]), .mem_rd(mrd[1]),
    .mem_rdata(mrdata[1]), .mem_wr(mwr[1]), .mem_wdata(mwdata[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: preload under reset, write on mem_wr, read data pipelined.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int w = 0; w < 16; w++) mem[k][w] <= 32'd0;
        mem[k][0]  <= 32'hAAAA_BBBB;
        mem[k][1]  <= 32'hCAFE_F00D;
        mem[k][8]  <= 32'h1122_3344;
        mem[k][9]  <= 32'h1122_3344;
        mem[k][10] <= 32'h1122_3344;
        mem[k][11] <= 32'h1122_3344;
        mem[k][12] <= 32'h1122_3344;
      end else if (mwr[k]) begin
        mem[k][maddr[k][3:0]] <= mwdata[k];
      end
      vp[k][0] <= mrd[k] && !rst;
      dp[k][0] <= mem[k][maddr[k][3:0]];
      for (int s = 1; s < 4; s++) begin
        vp[k][s] <= vp[k][s-1];
        dp[k][s] <= dp[k][s-1];
      end
    end
  end

  assign mrdata[0] = vp[0][0] ? dp[0][0] : BAD;
  assign mrdata[1] = vp[1][2] ? dp[1][2] : BAD;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  // Monitor: pop the expectation on every done pulse and compare.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (rst) begin
      rd_cnt[0] = 0;
      rd_cnt[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mrd[k]) begin
          rd_cnt[k]++;
          rd_at[k] = cyc;
        end
        if (mwr[k] && !done[k]) chk("wr_without_done", k, 32'd1, 32'd0);
        if (done[k]) begin
          have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            chk("unexpected_done", k, 32'd1, 32'd0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("misaligned", k, 32'(mis[k]), 32'(e.err));
            chk("mem_wr", k, 32'(mwr[k]), 32'(!e.err));
            chk("done_cycle", k, 32'(cyc), 32'(e.done_cyc));
            chk("read_count", k, 32'(rd_cnt[k]), 32'(e.rd_exp));
            if (e.rd_exp == 1) chk("read_cycle", k, 32'(rd_at[k]), 32'(e.rd_cyc));
            if (!e.err) begin
              chk("mem_addr", k, 32'(maddr[k]), 32'(e.addr));
              chk("mem_wdata", k, mwdata[k], e.wdata);
            end
          end
          rd_cnt[k] = 0;
        end
      end
    end
  end

  task automatic push_exp(input bit err, input bit sub, input logic [29:0] a,
                          input logic [31:0] w);
    exp_t e;
    e.err   = err;
    e.addr  = a;
    e.wdata = w;
    e.rd_exp = sub ? 1 : 0;
    e.rd_cyc = cyc + 1;
    e.done_cyc = sub ? cyc + 3 : cyc + 1;
    q0.push_back(e);
    e.done_cyc = sub ? cyc + 5 : cyc + 1;
    q1.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("completion_timeout", 0, 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit err, input bit sub,
                       input logic [31:0] w);
    push_exp(err, sub, a[31:2], w);
    drive(a, d, s);
    wait_empty();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_done", k, 32'(done[k]), 32'd0);
      chk("rst_misaligned", k, 32'(mis[k]), 32'd0);
      chk("rst_mem_rd", k, 32'(mrd[k]), 32'd0);
      chk("rst_mem_wr", k, 32'(mwr[k]), 32'd0);
      chk("rst_mem_addr", k, 32'(maddr[k]), 32'd0);
      chk("rst_mem_wdata", k, mwdata[k], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 0, 32'(ready[0]), 32'd1);
    chk("ready_after_rst", 1, 32'(ready[1]), 32'd1);

    // Word store
    store(32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF);
    // Byte store into every lane of 0x1122_3344
    store(32'h0000_0020, 32'hFFFF_FFAB, 2'b00, 1'b0, 1'b1, 32'h1122_33AB);
    store(32'h0000_0025, 32'hFFFF_FFAB, 2'b00, 1'b0, 1'b1, 32'h1122_AB44);
    store(32'h0000_002A, 32'hFFFF_FFAB, 2'b00, 1'b0, 1'b1, 32'h11AB_3344);
    store(32'h0000_002F, 32'hFFFF_FFAB, 2'b00, 1'b0, 1'b1, 32'hAB22_3344);
    // Halfword stores, upper and lower half
    store(32'h0000_0102, 32'h0000_1234, 2'b01, 1'b0, 1'b1, 32'h1234_BBBB);
    store(32'h0000_0104, 32'hFFFF_5678, 2'b01, 1'b0, 1'b1, 32'hCAFE_5678);
    // Rejected requests
    store(32'h0000_0101, 32'h0000_1111, 2'b01, 1'b1, 1'b0, 32'd0);
    store(32'h0000_0102, 32'h2222_2222, 2'b10, 1'b1, 1'b0, 32'd0);
    store(32'h0000_0000, 32'h3333_3333, 2'b11, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("mem_word8", k, mem[k][8], 32'h1122_33AB);
      chk("mem_word11", k, mem[k][11], 32'hAB22_3344);
    end

    // Reset while waiting for read data: nothing may be written or completed
    drive(32'h0000_0100, 32'h0000_9999, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_mid_rst", 0, 32'(ready[0]), 32'd1);
    chk("ready_after_mid_rst", 1, 32'(ready[1]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("mem_after_mid_rst", 1, mem[1][0], 32'hAAAA_BBBB);
    store(32'h0000_003C, 32'h0123_4567, 2'b10, 1'b0, 1'b0, 32'h0123_4567);

    // Request while busy is ignored
    push_exp(1'b0, 1'b1, 30'hC, 32'h1122_33CD);
    drive(32'h0000_0030, 32'h0000_00CD, 2'b00);
    @(posedge clk); #1;
    req_addr  = 32'h0000_0034;
    req_wdata = 32'hFFFF_FFFF;
    req_size  = 2'b10;
    req_valid = 1'b1;
    chk("ready_busy", 0, 32'(ready[0]), 32'd0);
    chk("ready_busy", 1, 32'(ready[1]), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_empty();
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("busy_ignored", k, mem[k][13], 32'd0);
      chk("busy_store", k, mem[k][12], 32'h1122_33CD);
    end
    chk("queues_drained", 0, 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_rmw.md
# store_narrow_rmw

Store-side narrowing unit for the datapath's word-only data memory. It accepts a 32-bit store request of byte, halfword or word size and truncates the register value to the requested width. Sub-word stores are merged into the addressed memory word with a read-modify-write sequence; word stores are written directly. It sits between the execute/memory stage and the data memory. It performs the opposite conversion to the load-side sign/zero extension: narrowing on store where that widens on load.

## Interface
Parameters:
- RD_LATENCY, default 1: cycles from the `mem_rd` cycle to the cycle in which `mem_rdata` is valid. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  store request present.
- req_ready  output  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; only the low 8, 16 or 32 bits are used.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  high together with `done` when the request was rejected.
- mem_addr  output  30  word address, equal to `req_addr[31:2]` of the latched request.
- mem_rd  output  1  read strobe, one cycle wide.
- mem_rdata  input  32  memory read data.
- mem_wr  output  1  write strobe, one cycle wide.
- mem_wdata  output  32  full word to write.

## Operation
- Byte lanes are little-endian: lane k is bits [8k+7:8k], and lane k is selected by `addr[1:0] = k`.
- On accept, the unit latches addr, size and wdata.

State machine:
- **IDLE**
  - `req_ready = 1`.
  - On accept with an illegal request (size 11; halfword with `addr[0] = 1`; word with `addr[1:0] != 0`), go to ERR.
  - On accept with a word store, go to WRITE.
  - On accept with a byte or halfword store, go to READ.
- **READ**
  - `mem_rd = 1` and `mem_addr` valid.
  - Load `cnt = RD_LATENCY - 1`, then go to WAIT.
- **WAIT**
  - If `cnt == 0`: capture `mem_rdata` into the merge register, overwriting the selected lane(s), then go to WRITE.
  - Otherwise decrement `cnt`.
- **WRITE**
  - `mem_wr = 1`, `done = 1`, `mem_wdata` = merged word, or `req_wdata` for a word store.
  - Go to IDLE.
- **ERR**
  - `done = 1`, `misaligned = 1`, no memory strobe.
  - Go to IDLE.

Merge rules:
- Byte store: `wdata[7:0]` replaces lane `addr[1:0]`; the other three lanes keep the read data.
- Halfword store: `wdata[15:0]` replaces bits [15:0] when `addr[1] = 0`, or bits [31:16] when `addr[1] = 1`.
- Unused upper bits of `req_wdata` are discarded; no saturation and no sign check.

Outputs:
- All outputs are registered or decoded from state and registers only; there is no combinational path from `req_*` or `mem_rdata` to any output.
- `mem_addr` and `mem_wdata` are don't-care when their strobe is low, but must hold their latched values from READ through WRITE.

## Timing
- Reset: state IDLE, `cnt = 0`. Output values while reset is held:
  - `req_ready = 1` in the cycle after reset is released.
  - `done`, `misaligned`, `mem_rd` and `mem_wr` are 0.
  - `mem_addr` and `mem_wdata` are 0.
- Latency, counting cycle 0 as the accept cycle:
  - Word store: WRITE/`done` in cycle 1.
  - Illegal request: ERR/`done` in cycle 1.
  - Byte/halfword store: READ in cycle 1, WAIT in cycles 2..1+RD_LATENCY, WRITE/`done` in cycle 2+RD_LATENCY.
- With RD_LATENCY = 1, `mem_rdata` is sampled in the cycle immediately after `mem_rd`.
- Throughput:
  - A new request can be accepted in the cycle after `done`; there are no back-to-back accepts.
  - `req_valid` while busy is ignored and nothing is latched.
- Reset mid-operation: `rst` in any state returns the unit to IDLE at the next edge.
  - The strobe of an interrupted READ/WAIT/WRITE is never issued after reset.
  - A pending write is dropped, and `done` is not pulsed.
- `req_valid` held high after `done` starts a new transaction. It is the requester's duty to drop it.

## Test plan
- **Word store:** addr 0x0000_0010, wdata 0xDEAD_BEEF, size 10 -> cycle 1 has `mem_wr = 1`, `mem_addr = 0x4`, `mem_wdata = 0xDEAD_BEEF`, `done = 1`; `mem_rd` is never asserted.
- **Byte store, all four lanes:** memory word 0x1122_3344, wdata 0xFFFF_FFAB (RD_LATENCY = 1), for addr[1:0] = 0..3 -> written words 0x1122_33AB, 0x1122_AB44, 0x11AB_3344 and 0xAB22_3344; `done` in cycle 3.
- **Halfword store, RD_LATENCY = 3:** addr 0x102, memory 0xAAAA_BBBB, wdata 0x0000_1234 -> `mem_rd` in cycle 1, `mem_wr` and `done` in cycle 5, `mem_wdata = 0x1234_BBBB`.
- **Misaligned:** halfword at addr 0x101, word at 0x102, and size 11 -> each gives `done = misaligned = 1` in cycle 1 with no `mem_rd` or `mem_wr`.
- **Reset in WAIT** (RD_LATENCY = 3, `rst` high in cycle 2) -> no `mem_wr` and no `done`; `req_ready = 1` in the cycle after reset is released; a following word store completes normally.
- **Busy:** second `req_valid` pulse during WAIT -> ignored; only the first store is written; `req_ready` stays 0 until IDLE.
